// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline stall/flush sequencer with performance counters
// Optional dmem watchdog enabled by defining HAZ_WATCHDOG_EN.
module hazard_controller #(
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_branchTaken,
  input  logic             wb_halt,
  input  logic             ex_memRead,
  input  logic [REG_W-1:0] ex_writeReg,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_usesRt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {RUN, REDIRECT, HALTED} state_t;

  state_t state;
  logic   dbusy;
  logic   load_use;

  assign dbusy    = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use = ex_memRead && (ex_writeReg != '0) &&
                    ((ex_writeReg == id_rs) || (id_usesRt && (ex_writeReg == id_rt)));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (state == HALTED || wb_halt || dbusy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (state == REDIRECT) begin
      // Target already in PC; keep bubbling IF/ID until the fetch returns.
      pc_en      = ihit;
      ifid_flush = 1'b1;
    end else if (mem_branchTaken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      halt      <= 1'b0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != HALTED) begin
        cycle_cnt <= sat_inc(cycle_cnt);
        if (!pc_en) stall_cnt <= sat_inc(stall_cnt);
      end
      case (state)
        RUN: begin
          if (wb_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (!dbusy && mem_branchTaken) begin
            flush_cnt <= sat_inc(flush_cnt);
            if (!ihit) state <= REDIRECT;
          end
        end
        REDIRECT: begin
          if (wb_halt) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else if (ihit && !dbusy) begin
            state <= RUN;
          end
        end
        default: state <= HALTED;
      endcase
    end
  end

`ifdef HAZ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wdog_cnt;

  // Counts consecutive busy cycles; saturates at the limit so the flag stays meaningful.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (!dbusy) begin
      wdog_cnt <= '0;
    end else if (wdog_cnt != WD_W'(WDOG_LIMIT)) begin
      wdog_cnt <= wdog_cnt + WD_W'(1);
      if (wdog_cnt == WD_W'(WDOG_LIMIT - 1)) mem_timeout <= 1'b1;
    end
  end
`else
  assign mem_timeout = 1'b0;
`endif

endmodule
